// File: rtl/dftprobe_mux_sequencer.sv
// dftprobe_mux_sequencer: drives the one-hot enable lines (ten) of N_PROBE
// analog probe switches that share a single test access line. Every new
// connection goes through a break-before-make gap with all enables low. A
// settle interval follows, and then the downstream sampler is told it may
// capture. The capture handshake ends on cap_done.
//
// Optional build macro DFTPROBE_AUTOSCAN_EN adds a scan_start input. When it
// is set, the block steps through every probe from index 0 to N_PROBE-1 and
// waits for one cap_done on each probe.
module dftprobe_mux_sequencer #(
    parameter int N_PROBE    = 8,
    parameter int SEL_W      = 3,
    parameter int BBM_CYC    = 4,
    parameter int SETTLE_CYC = 16,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req,
    input  logic [SEL_W-1:0]   req_sel,
    output logic               req_ack,
    input  logic               rel,
    input  logic               cap_done,
`ifdef DFTPROBE_AUTOSCAN_EN
    input  logic               scan_start,
`endif
    output logic [N_PROBE-1:0] ten,
    output logic               probe_ready,
    output logic               busy,
    output logic               err_sel,
    output logic [SEL_W-1:0]   cur_sel
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BREAK,
        ST_SETTLE,
        ST_READY
    } state_t;

    localparam logic [CNT_W-1:0] BBM_LAST    = CNT_W'(BBM_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    // One extra bit, so that N_PROBE == 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0]   SEL_LIMIT   = (SEL_W + 1)'(N_PROBE);
`ifdef DFTPROBE_AUTOSCAN_EN
    localparam logic [SEL_W-1:0] LAST_SEL    = SEL_W'(N_PROBE - 1);
`endif

    state_t             state;
    logic [CNT_W-1:0]   timer;
    logic [CNT_W-1:0]   timer_inc;
    logic               sel_valid;
    logic [N_PROBE-1:0] sel_onehot;
`ifdef DFTPROBE_AUTOSCAN_EN
    logic               scan_active;
`endif

    // The timer saturates and does not wrap. The decoded enable depends only
    // on the latched index, so ten can only have one bit set.
    assign timer_inc  = (timer == '1) ? timer : timer + 1'b1;
    assign sel_valid  = ({1'b0, req_sel} < SEL_LIMIT);
    assign sel_onehot = {{(N_PROBE-1){1'b0}}, 1'b1} << cur_sel;

    // Sequencer FSM. All outputs are registered. rel overrides every other input.
    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            timer       <= '0;
            ten         <= '0;
            probe_ready <= 1'b0;
            busy        <= 1'b0;
            req_ack     <= 1'b0;
            err_sel     <= 1'b0;
            cur_sel     <= '0;
`ifdef DFTPROBE_AUTOSCAN_EN
            scan_active <= 1'b0;
`endif
        end else begin
            req_ack <= 1'b0;
            err_sel <= 1'b0;
            if (rel) begin
                state       <= ST_IDLE;
                ten         <= '0;
                probe_ready <= 1'b0;
                busy        <= 1'b0;
                timer       <= '0;
`ifdef DFTPROBE_AUTOSCAN_EN
                scan_active <= 1'b0;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        // req_ack high means a request was accepted on the last
                        // edge. The break starts now, and the old probe stays
                        // connected for the acknowledge cycle.
                        if (req_ack) begin
                            state <= ST_BREAK;
                            ten   <= '0;
                            timer <= '0;
                            busy  <= 1'b1;
                        end
`ifdef DFTPROBE_AUTOSCAN_EN
                        else if (scan_start) begin
                            cur_sel     <= '0;
                            scan_active <= 1'b1;
                            state       <= ST_BREAK;
                            ten         <= '0;
                            timer       <= '0;
                            busy        <= 1'b1;
                        end
`endif
                        else if (req) begin
                            if (sel_valid) begin
                                cur_sel <= req_sel;
                                req_ack <= 1'b1;
                            end else begin
                                err_sel <= 1'b1;
                            end
                        end
                    end
                    ST_BREAK: begin
                        if (timer == BBM_LAST) begin
                            state <= ST_SETTLE;
                            ten   <= sel_onehot;
                            timer <= '0;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                    ST_SETTLE: begin
                        if (timer == SETTLE_LAST) begin
                            state       <= ST_READY;
                            probe_ready <= 1'b1;
                            timer       <= '0;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                    ST_READY: begin
                        if (cap_done) begin
                            probe_ready <= 1'b0;
                            timer       <= '0;
`ifdef DFTPROBE_AUTOSCAN_EN
                            if (scan_active) begin
                                if (cur_sel == LAST_SEL) begin
                                    state       <= ST_IDLE;
                                    ten         <= '0;
                                    busy        <= 1'b0;
                                    scan_active <= 1'b0;
                                end else begin
                                    cur_sel <= cur_sel + 1'b1;
                                    state   <= ST_BREAK;
                                    ten     <= '0;
                                end
                            end else
`endif
                            begin
                                // The probe stays connected after a single capture.
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dftprobe_mux_sequencer.sv
// tb_dftprobe_mux_sequencer: self-checking bench for dftprobe_mux_sequencer.
// The DUT is built with SEL_W=4, so that out-of-range indices (>= 8) can be driven.
// Expected connections go into a scoreboard queue when stimulus is driven.
// Each entry is popped and compared when probe_ready rises.
module tb_dftprobe_mux_sequencer;

    localparam int N_PROBE = 8;
    localparam int SEL_W   = 4;

    typedef struct {
        int sel;
        int ready_cyc;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               req;
    logic [SEL_W-1:0]   req_sel;
    logic               req_ack;
    logic               rel;
    logic               cap_done;
`ifdef DFTPROBE_AUTOSCAN_EN
    logic               scan_start;
`endif
    logic [N_PROBE-1:0] ten;
    logic               probe_ready;
    logic               busy;
    logic               err_sel;
    logic [SEL_W-1:0]   cur_sel;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    exp_t exp_q[$];
    logic [N_PROBE-1:0] prev_ten   = '0;
    logic               prev_ready = 1'b0;

    dftprobe_mux_sequencer #(
        .N_PROBE   (N_PROBE),
        .SEL_W     (SEL_W),
        .BBM_CYC   (4),
        .SETTLE_CYC(16),
        .CNT_W     (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_sel    (req_sel),
        .req_ack    (req_ack),
        .rel        (rel),
        .cap_done   (cap_done),
`ifdef DFTPROBE_AUTOSCAN_EN
        .scan_start (scan_start),
`endif
        .ten        (ten),
        .probe_ready(probe_ready),
        .busy       (busy),
        .err_sel    (err_sel),
        .cur_sel    (cur_sel)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [N_PROBE-1:0] onehot(input int sel);
        logic [N_PROBE-1:0] one;
        one = 1;
        return one << sel;
    endfunction

    // Advance one clock. Inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 64 && !probe_ready; i++) tick();
        check("ready_seen", probe_ready, 1);
    endtask

    task automatic push_exp(input int sel, input int delay);
        exp_t e;
        e.sel       = sel;
        e.ready_cyc = cyc + delay;
        exp_q.push_back(e);
    endtask

    // Checks the one-hot rule and the no-direct-switch rule on every cycle.
    // Scores each rising edge of probe_ready against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("onehot0", $onehot0(ten), 1);
            check("no_direct_switch", (prev_ten != 0 && ten != 0 && ten != prev_ten), 0);
            if (probe_ready && !prev_ready) begin
                check("sb_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sb_ten", ten, onehot(e.sel));
                    check("sb_cur_sel", cur_sel, e.sel);
                    check("sb_latency", cyc, e.ready_cyc);
                end
            end
        end
        prev_ten   = ten;
        prev_ready = probe_ready;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req = 1'b0; req_sel = '0; rel = 1'b0; cap_done = 1'b0;
`ifdef DFTPROBE_AUTOSCAN_EN
        scan_start = 1'b0;
`endif
        #3;
        check("rst_ten", ten, 0);
        check("rst_ready", probe_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_ack", req_ack, 0);
        check("rst_err", err_sel, 0);
        check("rst_cur_sel", cur_sel, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Request probe 5 from IDLE. The accept edge is the next edge; ready follows 21 cycles after it.
        req = 1'b1; req_sel = 5; push_exp(5, 22);
        tick();
        check("p5_ack", req_ack, 1);
        check("p5_ack_ten", ten, 0);
        req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("p5_break_ten", ten, 0);
            check("p5_break_busy", busy, 1);
            check("p5_break_ack", req_ack, 0);
        end
        tick();
        check("p5_settle_ten", ten, 8'h20);
        check("p5_settle_ready", probe_ready, 0);
        wait_ready();
        cap_done = 1'b1;
        tick();
        cap_done = 1'b0;
        check("p5_done_ready", probe_ready, 0);
        check("p5_done_busy", busy, 0);
        check("p5_done_ten", ten, 8'h20);

        // Probe 5 is held. A request for 2 must still break before it connects.
        tick();
        req = 1'b1; req_sel = 2; push_exp(2, 22);
        tick();
        check("p2_ack", req_ack, 1);
        check("p2_ack_ten_held", ten, 8'h20);
        req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("p2_break_ten", ten, 0);
        end
        tick();
        check("p2_settle_ten", ten, 8'h04);
        wait_ready();
        cap_done = 1'b1;
        tick();
        cap_done = 1'b0;
        check("p2_done_ten", ten, 8'h04);

        // Out-of-range index.
        req = 1'b1; req_sel = 9;
        tick();
        check("err_pulse", err_sel, 1);
        check("err_no_ack", req_ack, 0);
        check("err_busy", busy, 0);
        check("err_ten", ten, 8'h04);
        req = 1'b0;
        tick();
        check("err_pulse_end", err_sel, 0);
        check("err_ten_after", ten, 8'h04);

        // rel and req arrive together in READY. rel wins.
        req = 1'b1; req_sel = 3; push_exp(3, 22);
        tick();
        check("p3_ack", req_ack, 1);
        req = 1'b0;
        wait_ready();
        rel = 1'b1; req = 1'b1; req_sel = 1;
        tick();
        rel = 1'b0; req = 1'b0;
        check("rel_ten", ten, 0);
        check("rel_ready", probe_ready, 0);
        check("rel_busy", busy, 0);
        check("rel_no_ack", req_ack, 0);
        tick();
        check("rel_no_ack_late", req_ack, 0);
        check("rel_ten_late", ten, 0);

        // req and cap_done during BREAK are both ignored.
        req = 1'b1; req_sel = 7; push_exp(7, 22);
        tick();
        check("p7_ack", req_ack, 1);
        req = 1'b0;
        tick();
        req = 1'b1; req_sel = 1; cap_done = 1'b1;
        tick();
        check("busy_req_ignored", req_ack, 0);
        check("busy_cap_ignored", busy, 1);
        req = 1'b0; cap_done = 1'b0;
        wait_ready();
        check("p7_ten", ten, 8'h80);
        cap_done = 1'b1;
        tick();
        cap_done = 1'b0;
        check("p7_done_busy", busy, 0);

        // Asynchronous reset in the middle of SETTLE with probe 2 connected.
        req = 1'b1; req_sel = 2; push_exp(2, 22);
        tick();
        req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("mid_settle_ten", ten, 8'h04);
        check("mid_settle_ready", probe_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ten", ten, 0);
        check("async_rst_ready", probe_ready, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_cur_sel", cur_sel, 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();

`ifdef DFTPROBE_AUTOSCAN_EN
        // Autoscan: steps through every probe in order, with a break gap before each step.
        scan_start = 1'b1; push_exp(0, 21);
        tick();
        scan_start = 1'b0;
        check("scan_busy_start", busy, 1);
        for (int i = 0; i < N_PROBE; i++) begin
            wait_ready();
            check("scan_ten", ten, onehot(i));
            check("scan_busy", busy, 1);
            tick(); tick();
            cap_done = 1'b1;
            if (i < N_PROBE - 1) push_exp(i + 1, 21);
            tick();
            cap_done = 1'b0;
            check("scan_gap_ten", ten, 0);
            check("scan_gap_busy", busy, (i < N_PROBE - 1) ? 1 : 0);
        end
        tick();
        check("scan_end_ten", ten, 0);
        check("scan_end_busy", busy, 0);
`endif

        tick(); tick();
        check("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
